// File: rtl/kb_pkg.sv
// Shared scan-code, ASCII and FSM definitions for the PS/2 keyboard to UART bridge.
package kb_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } kb_state_t;

    // Lower-case ASCII letter to upper case.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return c - 8'h20;
    endfunction

endpackage

// File: rtl/ps2_kb_ascii_bridge_if.sv
// Scan-byte input, UART write handshake and status signals of the keyboard bridge.
interface ps2_kb_ascii_bridge_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       tx_full;
    logic       clr_ovf;
    logic       wr_uart;
    logic [7:0] wr_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic       ovf;
    logic       shift_o;
    logic       caps_o;

    modport master (
        output scan_valid, scan_code, tx_full, clr_ovf,
        input  wr_uart, wr_data, fifo_empty, fifo_full, ovf, shift_o, caps_o
    );

    modport slave (
        input  scan_valid, scan_code, tx_full, clr_ovf,
        output wr_uart, wr_data, fifo_empty, fifo_full, ovf, shift_o, caps_o
    );
endinterface

// File: rtl/kb_ascii_map.sv
// Combinational US-layout scan-code set 2 to ASCII translation with shift/caps handling.
module kb_ascii_map
    import kb_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0] lower;
    logic [7:0] upper;
    logic       letter;

    always_comb begin
        lower  = 8'h00;
        upper  = 8'h00;
        letter = 1'b0;
        hit    = 1'b1;
        case (scan_code)
            8'h1C: begin lower = "a"; letter = 1'b1; end
            8'h32: begin lower = "b"; letter = 1'b1; end
            8'h21: begin lower = "c"; letter = 1'b1; end
            8'h23: begin lower = "d"; letter = 1'b1; end
            8'h24: begin lower = "e"; letter = 1'b1; end
            8'h2B: begin lower = "f"; letter = 1'b1; end
            8'h34: begin lower = "g"; letter = 1'b1; end
            8'h33: begin lower = "h"; letter = 1'b1; end
            8'h43: begin lower = "i"; letter = 1'b1; end
            8'h3B: begin lower = "j"; letter = 1'b1; end
            8'h42: begin lower = "k"; letter = 1'b1; end
            8'h4B: begin lower = "l"; letter = 1'b1; end
            8'h3A: begin lower = "m"; letter = 1'b1; end
            8'h31: begin lower = "n"; letter = 1'b1; end
            8'h44: begin lower = "o"; letter = 1'b1; end
            8'h4D: begin lower = "p"; letter = 1'b1; end
            8'h15: begin lower = "q"; letter = 1'b1; end
            8'h2D: begin lower = "r"; letter = 1'b1; end
            8'h1B: begin lower = "s"; letter = 1'b1; end
            8'h2C: begin lower = "t"; letter = 1'b1; end
            8'h3C: begin lower = "u"; letter = 1'b1; end
            8'h2A: begin lower = "v"; letter = 1'b1; end
            8'h1D: begin lower = "w"; letter = 1'b1; end
            8'h22: begin lower = "x"; letter = 1'b1; end
            8'h35: begin lower = "y"; letter = 1'b1; end
            8'h1A: begin lower = "z"; letter = 1'b1; end
            8'h16: begin lower = "1"; upper = "!"; end
            8'h1E: begin lower = "2"; upper = "@"; end
            8'h26: begin lower = "3"; upper = "#"; end
            8'h25: begin lower = "4"; upper = "$"; end
            8'h2E: begin lower = "5"; upper = "%"; end
            8'h36: begin lower = "6"; upper = "^"; end
            8'h3D: begin lower = "7"; upper = "&"; end
            8'h3E: begin lower = "8"; upper = "*"; end
            8'h46: begin lower = "9"; upper = "("; end
            8'h45: begin lower = "0"; upper = ")"; end
            8'h0E: begin lower = 8'h60; upper = "~"; end
            8'h4E: begin lower = "-"; upper = "_"; end
            8'h55: begin lower = "="; upper = "+"; end
            8'h54: begin lower = "["; upper = "{"; end
            8'h5B: begin lower = "]"; upper = "}"; end
            8'h5D: begin lower = "\\"; upper = "|"; end
            8'h4C: begin lower = ";"; upper = ":"; end
            8'h52: begin lower = "'"; upper = "\""; end
            8'h41: begin lower = ","; upper = "<"; end
            8'h49: begin lower = "."; upper = ">"; end
            8'h4A: begin lower = "/"; upper = "?"; end
            // Control keys produce the same code regardless of modifiers.
            8'h29:    begin lower = 8'h20; upper = 8'h20; end
            SC_ENTER: begin lower = CR;    upper = CR;    end
            8'h66:    begin lower = BS;    upper = BS;    end
            8'h0D:    begin lower = TAB;   upper = TAB;   end
            8'h76:    begin lower = ESC;   upper = ESC;   end
            default:  hit = 1'b0;
        endcase
        if (letter)
            ascii = (shift ^ caps) ? to_upper(lower) : lower;
        else
            ascii = shift ? upper : lower;
    end

endmodule

// File: rtl/ps2_kb_ascii_bridge.sv
// PS/2 scan-code parser, ASCII character FIFO and UART drain.
// Optional KB_CRLF_EN: Enter pushes CR followed by LF on the next cycle.
module ps2_kb_ascii_bridge
    import kb_pkg::*;
#(
    parameter int         FIFO_W        = 4,
    parameter bit         CAPS_EN       = 1'b1,
    parameter logic [7:0] UNMAPPED_CHAR = 8'h00
) (
    input logic                 clk,
    input logic                 rst,
    ps2_kb_ascii_bridge_if.slave bus
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W+1:0] DEPTH_X = DEPTH[FIFO_W+1:0];
`ifdef KB_CRLF_EN
    localparam bit CRLF_ON = 1'b1;
`else
    localparam bit CRLF_ON = 1'b0;
`endif

    kb_state_t state, state_nxt;
    logic shift_l, shift_l_nxt;
    logic shift_r, shift_r_nxt;
    logic caps, caps_nxt;
    logic lf_pend, lf_set;
    logic ovf_q, ovf_set;

    logic       push_req, crlf_req, wr_en;
    logic [7:0] push_data;
    logic [7:0] map_ascii;
    logic       map_hit;
    logic       scan_fire;

    logic [7:0]      mem [DEPTH];
    logic [FIFO_W:0] wptr, rptr, count;
    logic            empty, full, pop, room2;

    kb_ascii_map u_map (
        .scan_code (bus.scan_code),
        .shift     (shift_l | shift_r),
        .caps      (caps),
        .ascii     (map_ascii),
        .hit       (map_hit)
    );

    // The LF cycle after an Enter owns the FIFO write port; no byte is taken then.
    assign scan_fire = bus.scan_valid && !lf_pend;

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_W] != rptr[FIFO_W]) &&
                   (wptr[FIFO_W-1:0] == rptr[FIFO_W-1:0]);
    assign pop   = !empty && !bus.tx_full;
    assign room2 = ({1'b0, count} + {{FIFO_W{1'b0}}, 2'd2}) <=
                   (DEPTH_X + {{(FIFO_W+1){1'b0}}, pop});

    always_comb begin
        state_nxt   = state;
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
        caps_nxt    = caps;
        push_req    = 1'b0;
        crlf_req    = 1'b0;
        push_data   = map_ascii;
        if (lf_pend) begin
            push_req  = 1'b1;
            push_data = LF;
        end
        if (scan_fire) begin
            case (state)
                IDLE: begin
                    if (bus.scan_code == SC_BREAK)
                        state_nxt = BRK;
                    else if (bus.scan_code == SC_EXT)
                        state_nxt = EXT;
                    else if (bus.scan_code == SC_LSHIFT)
                        shift_l_nxt = 1'b1;
                    else if (bus.scan_code == SC_RSHIFT)
                        shift_r_nxt = 1'b1;
                    else if (bus.scan_code == SC_CAPS) begin
                        if (CAPS_EN)
                            caps_nxt = !caps;
                    end else if (CRLF_ON && bus.scan_code == SC_ENTER) begin
                        crlf_req  = 1'b1;
                        push_data = CR;
                    end else if (map_hit)
                        push_req = 1'b1;
                    else if (UNMAPPED_CHAR != 8'h00) begin
                        push_req  = 1'b1;
                        push_data = UNMAPPED_CHAR;
                    end
                end
                BRK: begin
                    if (bus.scan_code == SC_LSHIFT)
                        shift_l_nxt = 1'b0;
                    else if (bus.scan_code == SC_RSHIFT)
                        shift_r_nxt = 1'b0;
                    state_nxt = IDLE;
                end
                EXT:     state_nxt = (bus.scan_code == SC_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A CR/LF pair is all-or-nothing; a pop this cycle frees one slot for it.
    always_comb begin
        wr_en   = 1'b0;
        ovf_set = 1'b0;
        lf_set  = 1'b0;
        if (crlf_req) begin
            if (room2) begin
                wr_en  = 1'b1;
                lf_set = 1'b1;
            end else
                ovf_set = 1'b1;
        end else if (push_req) begin
            if (!full || pop)
                wr_en = 1'b1;
            else
                ovf_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps    <= 1'b0;
            lf_pend <= 1'b0;
            ovf_q   <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
        end else begin
            state   <= state_nxt;
            shift_l <= shift_l_nxt;
            shift_r <= shift_r_nxt;
            caps    <= caps_nxt;
            lf_pend <= lf_set;
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[FIFO_W-1:0]] <= push_data;
    end

    assign bus.wr_uart    = pop;
    assign bus.wr_data    = mem[rptr[FIFO_W-1:0]];
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.ovf        = ovf_q;
    assign bus.shift_o    = shift_l | shift_r;
    assign bus.caps_o     = caps;

endmodule

// File: tb/tb_ps2_kb_ascii_bridge.sv
// Directed bench for ps2_kb_ascii_bridge: scan sequences in, UART bytes collected and compared.
module tb_ps2_kb_ascii_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_kb_ascii_bridge_if bus_if ();

    ps2_kb_ascii_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    logic [7:0] rxq [$];
    logic [7:0] expq [$];

    always @(negedge clk)
        if (!rst && bus_if.wr_uart)
            rxq.push_back(bus_if.wr_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (i < rxq.size()) ? rxq[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.scan_code  = b;
        bus_if.scan_valid = 1'b1;
        tick(1);
        bus_if.scan_valid = 1'b0;
        tick(1);
    endtask

    task automatic chk_rx(input string tag);
        chk({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_at(i), expq[i]);
    endtask

    task automatic fill16;
        bus_if.tx_full = 1'b1;
        for (int i = 0; i < 16; i++)
            send(8'h1C);
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.scan_valid = 1'b0;
        bus_if.scan_code  = 8'h00;
        bus_if.tx_full    = 1'b0;
        bus_if.clr_ovf    = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("rst_empty",   bus_if.fifo_empty, 1);
        chk("rst_full",    bus_if.fifo_full,  0);
        chk("rst_ovf",     bus_if.ovf,        0);
        chk("rst_shift",   bus_if.shift_o,    0);
        chk("rst_caps",    bus_if.caps_o,     0);
        chk("rst_wr_uart", bus_if.wr_uart,    0);

        // make/break of 'a', with first-write latency
        rxq.delete();
        bus_if.scan_code  = 8'h1C;
        bus_if.scan_valid = 1'b1;
        tick(1);
        bus_if.scan_valid = 1'b0;
        @(negedge clk);
        chk("lat_wr_uart", bus_if.wr_uart, 1);
        chk("lat_wr_data", bus_if.wr_data, 8'h61);
        @(posedge clk); #1;
        send(8'hF0); send(8'h1C);
        tick(4);
        expq = '{8'h61};
        chk_rx("make_break");

        // shift
        rxq.delete();
        send(8'h12);
        chk("shift_set", bus_if.shift_o, 1);
        send(8'h1C); send(8'hF0);
        chk("shift_mid_break", bus_if.shift_o, 1);
        send(8'h12);
        chk("shift_clr", bus_if.shift_o, 0);
        send(8'h1C);
        tick(4);
        expq = '{8'h41, 8'h61};
        chk_rx("shift");

        // caps lock
        rxq.delete();
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_on", bus_if.caps_o, 1);
        send(8'h1C); send(8'h12); send(8'h1C); send(8'h16);
        tick(4);
        expq = '{8'h41, 8'h61, 8'h21};
        chk_rx("caps");
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_off", bus_if.caps_o, 0);

        // extended arrow key discarded
        rxq.delete();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        tick(3);
        chk("ext_none", rxq.size(), 0);
        send(8'h1C);
        tick(3);
        expq = '{8'h61};
        chk_rx("ext_after");

        // punctuation, unmapped code, control keys
        rxq.delete();
        send(8'h12); send(8'h45); send(8'h4C);
        send(8'hF0); send(8'h12); send(8'h4C);
        send(8'h05); send(8'h29); send(8'h5A);
        tick(4);
        expq = '{8'h29, 8'h3A, 8'h3B, 8'h20, 8'h0D};
`ifdef KB_CRLF_EN
        expq.push_back(8'h0A);
`endif
        chk_rx("punct");

        // overflow with UART stalled
        rxq.delete();
        fill16;
        chk("ovf_full",    bus_if.fifo_full, 1);
        chk("ovf_pre",     bus_if.ovf,       0);
        chk("ovf_stalled", bus_if.wr_uart,   0);
        send(8'h1C);
        chk("ovf_set",     bus_if.ovf,       1);
        bus_if.tx_full = 1'b0;
        tick(20);
        expq = '{16{8'h61}};
        chk_rx("ovf_drain");
        chk("ovf_empty", bus_if.fifo_empty, 1);
        bus_if.clr_ovf = 1'b1;
        tick(1);
        bus_if.clr_ovf = 1'b0;
        chk("ovf_clr", bus_if.ovf, 0);

        // push and pop on the same edge while full
        rxq.delete();
        fill16;
        bus_if.tx_full    = 1'b0;
        bus_if.scan_code  = 8'h1C;
        bus_if.scan_valid = 1'b1;
        tick(1);
        bus_if.scan_valid = 1'b0;
        chk("pushpop_no_ovf", bus_if.ovf, 0);
        tick(20);
        chk("pushpop_count", rxq.size(), 17);
        chk("pushpop_empty", bus_if.fifo_empty, 1);

        // overflow set beats clr_ovf
        fill16;
        bus_if.clr_ovf    = 1'b1;
        bus_if.scan_code  = 8'h1C;
        bus_if.scan_valid = 1'b1;
        tick(1);
        bus_if.scan_valid = 1'b0;
        bus_if.clr_ovf    = 1'b0;
        chk("ovf_set_wins", bus_if.ovf, 1);
        bus_if.tx_full = 1'b0;
        tick(20);
        bus_if.clr_ovf = 1'b1;
        tick(1);
        bus_if.clr_ovf = 1'b0;

        // reset between F0 and its code
        bus_if.tx_full = 1'b1;
        send(8'h1C); send(8'h12);
        chk("midrst_shift_pre", bus_if.shift_o, 1);
        send(8'hF0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus_if.tx_full = 1'b0;
        chk("midrst_shift", bus_if.shift_o,    0);
        chk("midrst_empty", bus_if.fifo_empty, 1);
        send(8'h12);
        chk("midrst_idle_parse", bus_if.shift_o, 1);
        send(8'hF0); send(8'h12);

`ifdef KB_CRLF_EN
        rxq.delete();
        send(8'h5A);
        tick(4);
        expq = '{8'h0D, 8'h0A};
        chk_rx("crlf");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
